mode_tracker: RTL and testbench

//  - Parametrised, clocked successor of the combinational zero-detect -> mode_t mapper.
//  - Watches a WIDTH-bit valid-qualified word stream and tracks frame state in a registered mode_t FSM.
//  - Zero word = start marker; non-zero words = payload; zero word or MAX_LEN words = end of frame.
//  - Flags an idle timeout; used by testbench/datapath blocks as a frame-boundary monitor.

---
 rtl/mode_pkg.sv | 11 +
 rtl/idle_timer.sv | 37 +++
 rtl/mode_tracker.sv | 101 ++++++++++
 tb/tb_mode_tracker.sv | 122 ++++++++++++
 4 files changed

// File: rtl/mode_pkg.sv
// Shared frame-state encoding for the mode tracker and anything that decodes its mode output.
package mode_pkg;

    typedef enum logic [1:0] {
        START = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2,
        ERR   = 2'd3
    } mode_t;

endpackage

// File: rtl/idle_timer.sv
// Counts consecutive enabled cycles; expire fires on the TIMEOUT-th one.
module idle_timer #(
    parameter int TIMEOUT = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expire
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] LOAD = TW'(TIMEOUT - 1);

    // Down-counter holds the enabled cycles still allowed before expiry.
    logic [TW-1:0] remain_q, remain_d;

    always_comb begin
        remain_d = remain_q;
        if (clr) begin
            remain_d = LOAD;
        end else if (en) begin
            remain_d = (remain_q == '0) ? LOAD : remain_q - TW'(1);
        end
    end

    assign expire = en && !clr && (remain_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            remain_q <= LOAD;
        end else begin
            remain_q <= remain_d;
        end
    end

endmodule

// File: rtl/mode_tracker.sv
// Frame-boundary monitor: zero word opens a frame, payload is counted, and a zero word,
// MAX_LEN words or an idle timeout close it.
module mode_tracker
    import mode_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 16,
    parameter int TIMEOUT = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         clr,
    output mode_t                        mode,
    output logic [$clog2(MAX_LEN+1)-1:0] word_cnt,
    output logic                         done_pulse,
    output logic                         err
);

    localparam int CW = $clog2(MAX_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(MAX_LEN - 1);

    mode_t          mode_q, mode_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic           in_zero;
    logic           idle_en, idle_clr, idle_expire;

    assign in_zero  = (in_data == '0);
    assign idle_en  = (mode_q == RUN) && !in_valid;
    assign idle_clr = in_valid || clr || (mode_q != RUN);

    idle_timer #(.TIMEOUT(TIMEOUT)) u_idle_timer (
        .clk    (clk),
        .rst    (rst),
        .en     (idle_en),
        .clr    (idle_clr),
        .expire (idle_expire)
    );

    always_comb begin
        mode_d = mode_q;
        cnt_d  = cnt_q;
        if (clr) begin
            mode_d = START;
            cnt_d  = '0;
        end else begin
            unique case (mode_q)
                START: begin
                    if (in_valid && in_zero) begin
                        mode_d = RUN;
                        cnt_d  = '0;
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        if (!in_zero) begin
                            cnt_d = cnt_q + CW'(1);
                            if (cnt_q == LAST) mode_d = DONE;
                        end else if (cnt_q != '0) begin
                            mode_d = DONE;
                        end
                    end else if (idle_expire) begin
                        mode_d = ERR;
                    end
                end
                DONE, ERR: begin
                    mode_d = mode_q;
                end
                default: begin
                    mode_d = START;
                    cnt_d  = '0;
                end
            endcase
        end
        done_d = (mode_d == DONE) && (mode_q != DONE);
        err_d  = (mode_d == ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= START;
            cnt_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    assign mode       = mode_q;
    assign word_cnt   = cnt_q;
    assign done_pulse = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_mode_tracker.sv
// Directed bench for mode_tracker with WIDTH=8, MAX_LEN=4, TIMEOUT=5.
module tb_mode_tracker;
    import mode_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       clr;
    mode_t      mode;
    logic [2:0] word_cnt;
    logic       done_pulse;
    logic       err;

    int errors = 0;
    int checks = 0;

    mode_tracker #(.WIDTH(8), .MAX_LEN(4), .TIMEOUT(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .clr        (clr),
        .mode       (mode),
        .word_cnt   (word_cnt),
        .done_pulse (done_pulse),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input mode_t m, input int c, input bit d, input bit e);
        chk({tag, ".mode"}, int'(mode), int'(m));
        chk({tag, ".cnt"}, int'(word_cnt), c);
        chk({tag, ".done"}, int'(done_pulse), int'(d));
        chk({tag, ".err"}, int'(err), int'(e));
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit c);
        in_valid = v;
        in_data  = d;
        clr      = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h00; clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", START, 0, 1'b0, 1'b0);
        rst = 1'b0;

        // short frame terminated by zero
        step(1, 8'h00, 0); chk_all("t2_marker", RUN, 0, 0, 0);
        step(1, 8'h11, 0); chk_all("t2_w1", RUN, 1, 0, 0);
        step(1, 8'h22, 0); chk_all("t2_w2", RUN, 2, 0, 0);
        step(1, 8'h00, 0); chk_all("t2_term", DONE, 2, 1, 0);
        step(0, 8'h00, 0); chk_all("t2_hold", DONE, 2, 0, 0);
        step(0, 8'h00, 1); chk_all("t2_clr", START, 0, 0, 0);

        // frame closed by MAX_LEN
        step(1, 8'h00, 0); chk_all("t3_marker", RUN, 0, 0, 0);
        step(1, 8'h01, 0); chk_all("t3_w1", RUN, 1, 0, 0);
        step(1, 8'h02, 0); chk_all("t3_w2", RUN, 2, 0, 0);
        step(1, 8'h03, 0); chk_all("t3_w3", RUN, 3, 0, 0);
        step(1, 8'h04, 0); chk_all("t3_max", DONE, 4, 1, 0);
        step(1, 8'h05, 0); chk_all("t3_ign1", DONE, 4, 0, 0);
        step(1, 8'h00, 0); chk_all("t3_ign2", DONE, 4, 0, 0);
        step(0, 8'h00, 1); chk_all("t3_clr", START, 0, 0, 0);

        // idle timeout
        step(1, 8'h00, 0); chk_all("t4_marker", RUN, 0, 0, 0);
        idle(4);           chk_all("t4_idle4", RUN, 0, 0, 0);
        idle(1);           chk_all("t4_timeout", ERR, 0, 0, 1);
        idle(1);           chk_all("t4_errhold", ERR, 0, 0, 1);
        step(1, 8'h00, 0); chk_all("t4_errvalid", ERR, 0, 0, 1);
        step(0, 8'h00, 1); chk_all("t4_clr", START, 0, 0, 0);

        // valid word restarts idle count
        step(1, 8'h00, 0); chk_all("t4b_marker", RUN, 0, 0, 0);
        idle(4);           chk_all("t4b_idle4a", RUN, 0, 0, 0);
        step(1, 8'h55, 0); chk_all("t4b_word", RUN, 1, 0, 0);
        idle(4);           chk_all("t4b_idle4b", RUN, 1, 0, 0);
        idle(1);           chk_all("t4b_timeout", ERR, 1, 0, 1);
        step(0, 8'h00, 1); chk_all("t4b_clr", START, 0, 0, 0);

        // clr beats same-cycle valid
        step(1, 8'h00, 0); chk_all("t5_marker", RUN, 0, 0, 0);
        step(1, 8'h11, 0); chk_all("t5_w1", RUN, 1, 0, 0);
        step(1, 8'h22, 0); chk_all("t5_w2", RUN, 2, 0, 0);
        step(1, 8'h00, 1); chk_all("t5_clr", START, 0, 0, 0);
        step(0, 8'h00, 0); chk_all("t5_after", START, 0, 0, 0);

        // leading payload ignored, repeated marker tolerated, mid-frame reset
        step(1, 8'h7F, 0); chk_all("t6_7f", START, 0, 0, 0);
        step(1, 8'h80, 0); chk_all("t6_80", START, 0, 0, 0);
        step(1, 8'h00, 0); chk_all("t6_m1", RUN, 0, 0, 0);
        step(1, 8'h00, 0); chk_all("t6_m2", RUN, 0, 0, 0);
        step(1, 8'hAA, 0); chk_all("t6_aa", RUN, 1, 0, 0);
        rst = 1'b1;
        step(1, 8'h33, 0); chk_all("t6_rst", START, 0, 0, 0);
        rst = 1'b0;
        step(1, 8'h00, 0); chk_all("t6_restart", RUN, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
